// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED step sequencer: switch modes, rotator
// step codes, direction values and the FSM state type.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic [1:0] SW_NONE  = 2'b00;
    localparam logic [1:0] SW_LEFT  = 2'b01;
    localparam logic [1:0] SW_RIGHT = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int NUM_LED_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEFT  = 3'd1,
        ST_RIGHT = 3'd2,
        ST_BNC_L = 3'd3,
        ST_BNC_R = 3'd4
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Step-rate prescaler. Counts 0..limit while running, where
// limit = (STEP_DIV >> iSpeed) - 1, and flags the terminal cycle.
// A speed change that leaves the count at or above the new limit
// terminates the period at once instead of wrapping the counter.
module step_timer #(
    parameter int STEP_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRun,
    input  logic [1:0] iSpeed,
    output logic       oTick
);

    localparam logic [CNT_W-1:0] DIV = CNT_W'(STEP_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             w_at_limit;

    // Terminal compare against the limit for the current speed
    always_comb begin
        w_limit    = (DIV >> iSpeed) - ONE;
        w_at_limit = (r_cnt >= w_limit);
    end

    assign oTick = iRun & w_at_limit;

    // Period counter; held at zero while paused
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_cnt <= '0;
        end else if (!iRun) begin
            r_cnt <= '0;
        end else if (w_at_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// LED rotator step sequencer. Turns a programmable step rate into
// one-cycle iSW pulses for the rotator and mirrors the lit-LED index.
// Build option: define LED_STEP_CTRL_DWELL_EN to make bounce modes hold
// each end LED for one extra step period before reversing.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | hold mode; no steps, position frozen
// ST_LEFT  | rotate left (index up), wraps 9 -> 0
// ST_RIGHT | rotate right (index down), wraps 0 -> 9
// ST_BNC_L | ping-pong, currently moving left (index up)
// ST_BNC_R | ping-pong, currently moving right (index down)
module led_step_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int STEP_DIV = 25000000,
    parameter int CNT_W    = 25,
    parameter int NUM_LED  = NUM_LED_DEFAULT
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRun,
    input  logic [1:0] iMode,
    input  logic [1:0] iSpeed,
    output logic [1:0] oSW,
    output logic [3:0] oPos,
    output logic       oDir
);

    localparam logic [3:0] POS_MAX = 4'(NUM_LED - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_sw;
    logic [1:0] w_sw_nxt;
    logic [3:0] r_pos;
    logic [3:0] w_pos_nxt;
    logic       r_dir;
    logic       w_dir_nxt;
    logic       w_tick;
    logic       w_accept;
    logic       w_step_l;
    logic       w_step_r;
    logic       w_dwell_hit;

`ifdef LED_STEP_CTRL_DWELL_EN
    logic       r_dwell;
    logic       w_dwell_nxt;
    logic       w_bnc_step;
    assign w_dwell_hit = r_dwell;
`else
    assign w_dwell_hit = 1'b0;
`endif

    step_timer #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) u_step_timer (
        .iClk   (iClk),
        .iRst   (iRst),
        .iRun   (iRun),
        .iSpeed (iSpeed),
        .oTick  (w_tick)
    );

    // A tick landing while a pulse is still on oSW is dropped, so steps
    // are always at least two clocks apart even at the fastest speed.
    assign w_accept = w_tick & (r_sw == SW_NONE);

    // Next-state, step decision and mirrored position update
    always_comb begin
        w_state_nxt = r_state;
        w_sw_nxt    = SW_NONE;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_step_l    = 1'b0;
        w_step_r    = 1'b0;
`ifdef LED_STEP_CTRL_DWELL_EN
        w_dwell_nxt = r_dwell;
        w_bnc_step  = 1'b0;
`endif
        if (w_accept) begin
`ifdef LED_STEP_CTRL_DWELL_EN
            w_dwell_nxt = 1'b0;
`endif
            case (iMode)
                MODE_HOLD: begin
                    w_state_nxt = ST_IDLE;
                end
                MODE_LEFT: begin
                    w_state_nxt = ST_LEFT;
                    w_step_l    = 1'b1;
                end
                MODE_RIGHT: begin
                    w_state_nxt = ST_RIGHT;
                    w_step_r    = 1'b1;
                end
                default: begin
                    // A pending dwell swallows this tick with no step
                    if (!w_dwell_hit) begin
`ifdef LED_STEP_CTRL_DWELL_EN
                        w_bnc_step = 1'b1;
`endif
                        case (r_state)
                            ST_BNC_L: begin
                                if (r_pos == POS_MAX) begin
                                    w_state_nxt = ST_BNC_R;
                                    w_step_r    = 1'b1;
                                end else begin
                                    w_step_l    = 1'b1;
                                end
                            end
                            ST_BNC_R: begin
                                if (r_pos == 4'd0) begin
                                    w_state_nxt = ST_BNC_L;
                                    w_step_l    = 1'b1;
                                end else begin
                                    w_step_r    = 1'b1;
                                end
                            end
                            default: begin
                                if (r_pos == POS_MAX) begin
                                    w_state_nxt = ST_BNC_R;
                                    w_step_r    = 1'b1;
                                end else begin
                                    w_state_nxt = ST_BNC_L;
                                    w_step_l    = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            endcase

            // Bounce states reverse before reaching an end, so the wrap
            // arms below are only ever taken by the plain rotate modes.
            if (w_step_l) begin
                w_sw_nxt  = SW_LEFT;
                w_dir_nxt = DIR_LEFT;
                w_pos_nxt = (r_pos == POS_MAX) ? 4'd0 : r_pos + 4'd1;
            end else if (w_step_r) begin
                w_sw_nxt  = SW_RIGHT;
                w_dir_nxt = DIR_RIGHT;
                w_pos_nxt = (r_pos == 4'd0) ? POS_MAX : r_pos - 4'd1;
            end

`ifdef LED_STEP_CTRL_DWELL_EN
            if (w_bnc_step && ((w_pos_nxt == 4'd0) || (w_pos_nxt == POS_MAX))) begin
                w_dwell_nxt = 1'b1;
            end
`endif
        end
    end

    // State and output registers; oSW, oPos and oDir change together
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_sw    <= SW_NONE;
            r_pos   <= 4'd0;
            r_dir   <= DIR_LEFT;
        end else begin
            r_state <= w_state_nxt;
            r_sw    <= w_sw_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

`ifdef LED_STEP_CTRL_DWELL_EN
    // End-of-travel dwell flag
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_dwell <= 1'b0;
        end else begin
            r_dwell <= w_dwell_nxt;
        end
    end
`endif

    assign oSW  = r_sw;
    assign oPos = r_pos;
    assign oDir = r_dir;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with STEP_DIV=8, NUM_LED=10.
// Expected pulses (code, position, direction, clocks since previous
// pulse or since reset release) are queued before each scenario and
// consumed by a monitor whenever oSW is non-zero.
module tb_led_step_ctrl;

`ifdef LED_STEP_CTRL_DWELL_EN
    localparam int DW = 1;
`else
    localparam int DW = 0;
`endif

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iRun = 1'b0;
    logic [1:0] iMode = 2'b00;
    logic [1:0] iSpeed = 2'b00;
    logic [1:0] oSW;
    logic [3:0] oPos;
    logic       oDir;

    led_step_ctrl #(
        .STEP_DIV (8),
        .CNT_W    (4),
        .NUM_LED  (10)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iRun   (iRun),
        .iMode  (iMode),
        .iSpeed (iSpeed),
        .oSW    (oSW),
        .oPos   (oPos),
        .oDir   (oDir)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [1:0] sw;
        logic [3:0] pos;
        logic       dir;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    bit   mon = 1'b0;
    int   bp;
    int   bd;
    bit   brev;

    always @(posedge iClk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [1:0] sw, input logic [3:0] pos, input logic dir, input int gap);
        exp_t e;
        e.sw  = sw;
        e.pos = pos;
        e.dir = dir;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic drain(input string tag);
        chk(tag, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic do_reset(input logic run_v, input logic [1:0] mode_v, input logic [1:0] speed_v);
        iRst = 1'b1;
        iRun = 1'b0;
        repeat (2) @(negedge iClk);
        chk("rst_sw", 32'(oSW), 32'd0);
        chk("rst_pos", 32'(oPos), 32'd0);
        chk("rst_dir", 32'(oDir), 32'd0);
        iRun   = run_v;
        iMode  = mode_v;
        iSpeed = speed_v;
        iRst   = 1'b0;
        last_pulse = cyc;
    endtask

    // Pulse monitor / scoreboard consumer
    always @(negedge iClk) begin
        if (mon && (oSW !== 2'b00)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(oSW), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_sw", 32'(oSW), 32'(e.sw));
                chk("pulse_pos", 32'(oPos), 32'(e.pos));
                chk("pulse_dir", 32'(oDir), 32'(e.dir));
                chk("pulse_gap", 32'(cyc - last_pulse), 32'(e.gap));
            end
            last_pulse = cyc;
        end
    end

    initial begin
        // Rotate left from reset with wrap 9 -> 0
        for (int k = 1; k <= 11; k++) begin
            push_exp(2'b01, 4'(k % 10), 1'b0, 8);
        end
        mon = 1'b1;
        do_reset(1'b1, 2'b01, 2'b00);
        run(92);
        iRun = 1'b0;
        run(4);
        drain("left_count");
        chk("left_end_pos", 32'(oPos), 32'd1);

        // Rotate right from reset wraps 0 -> 9 first
        push_exp(2'b10, 4'd9, 1'b1, 8);
        push_exp(2'b10, 4'd8, 1'b1, 8);
        push_exp(2'b10, 4'd7, 1'b1, 8);
        do_reset(1'b1, 2'b10, 2'b00);
        run(28);
        iRun = 1'b0;
        run(4);
        drain("right_count");
        chk("right_end_dir", 32'(oDir), 32'd1);

        // Bounce from position 0: 1..9, 8..0, 1
        bp = 0;
        bd = 0;
        for (int k = 0; k < 19; k++) begin
            brev = 1'b0;
            if (bd == 0 && bp == 9) begin
                bd = 1;
                brev = 1'b1;
            end else if (bd == 1 && bp == 0) begin
                bd = 0;
                brev = 1'b1;
            end
            bp = (bd == 1) ? bp - 1 : bp + 1;
            push_exp((bd == 1) ? 2'b10 : 2'b01, 4'(bp), 1'(bd), brev ? 8 + 8 * DW : 8);
        end
        do_reset(1'b1, 2'b11, 2'b00);
        run(19 * 8 + 16 * DW + 4);
        iRun = 1'b0;
        run(4);
        drain("bounce_count");
        chk("bounce_end_pos", 32'(oPos), 32'd1);

        // Speed 0 -> 3 while the count is 5
        for (int k = 1; k <= 6; k++) begin
            push_exp(2'b01, 4'(k), 1'b0, (k == 1) ? 6 : 2);
        end
        do_reset(1'b1, 2'b01, 2'b00);
        run(5);
        iSpeed = 2'b11;
        run(11);
        iRun = 1'b0;
        run(4);
        drain("speed_count");
        iSpeed = 2'b00;

        // Pause for 20 clocks, resume, then hold mode
        push_exp(2'b01, 4'd1, 1'b0, 8);
        push_exp(2'b01, 4'd2, 1'b0, 8);
        push_exp(2'b01, 4'd3, 1'b0, 32);
        push_exp(2'b01, 4'd4, 1'b0, 8);
        do_reset(1'b1, 2'b01, 2'b00);
        run(20);
        iRun = 1'b0;
        run(20);
        chk("pause_pos", 32'(oPos), 32'd2);
        iRun = 1'b1;
        run(20);
        iMode = 2'b00;
        run(24);
        chk("hold_pos", 32'(oPos), 32'd4);
        chk("hold_dir", 32'(oDir), 32'd0);
        iRun = 1'b0;
        run(2);
        drain("pause_hold_count");

        // Bounce entered at the top end reverses immediately
        push_exp(2'b10, 4'd9, 1'b1, 8);
        push_exp(2'b10, 4'd8, 1'b1, 8);
        push_exp(2'b10, 4'd7, 1'b1, 8);
        do_reset(1'b1, 2'b10, 2'b00);
        run(8);
        iMode = 2'b11;
        run(20);
        iRun = 1'b0;
        run(4);
        drain("bounce_top_count");

        // Asynchronous reset while a pulse is on oSW
        mon = 1'b0;
        do_reset(1'b1, 2'b01, 2'b00);
        run(8);
        chk("pre_rst_sw", 32'(oSW), 32'd1);
        chk("pre_rst_pos", 32'(oPos), 32'd1);
        #1 iRst = 1'b1;
        #1;
        chk("async_rst_sw", 32'(oSW), 32'd0);
        chk("async_rst_pos", 32'(oPos), 32'd0);
        chk("async_rst_dir", 32'(oDir), 32'd0);
        run(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
